// File: rtl/inference_frame_controller_pkg.sv
// Shared types and default constants for the inference frame controller.
// The state enum lives here so the controller and bench agree on one encoding.
package ifc_pkg;

  localparam int DEF_WIDTH       = 37;
  localparam int DEF_NFRAC       = 24;
  localparam int DEF_INPUT_SIZE  = 16;
  localparam int DEF_OUTPUT_SIZE = 5;
  localparam int DEF_TIMEOUT     = 1024;
  localparam int DEF_CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } ifc_state_e;

endpackage

// File: rtl/inference_frame_controller_if.sv
// Valid/ready/last feature stream carrying one signed fixed-point feature per beat.
interface inference_frame_controller_if
  import ifc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic                    valid;
  logic                    ready;
  logic                    last;
  logic signed [WIDTH-1:0] data;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);

endinterface

// File: rtl/inference_frame_controller_lat_counter.sv
// Core latency counter: clear loads 1, enable counts up saturating, expired
// flags that the count has reached the timeout bound.
module lat_counter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = CNT_W'(1);
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q >= TIMEOUT_C);

endmodule

// File: rtl/inference_frame_controller.sv
// Assembles streamed features into a frame for the inference core, times the
// core, and streams its results back out while keeping error and latency stats.
module inference_frame_controller
  import ifc_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NFRAC       = DEF_NFRAC,
  parameter int INPUT_SIZE  = DEF_INPUT_SIZE,
  parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  inference_frame_controller_if.slave  s_if,
  inference_frame_controller_if.master m_if,
  output logic                    core_input_ready,
  output logic signed [WIDTH-1:0] core_input_data [INPUT_SIZE],
  input  logic                    core_output_ready,
  input  logic signed [WIDTH-1:0] core_output_data [OUTPUT_SIZE],
  output logic                    err_len,
  output logic                    err_timeout,
  output logic [CNT_W-1:0]        frame_count,
  output logic [CNT_W-1:0]        last_latency,
  output logic [CNT_W-1:0]        max_latency
);

  localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int ODX_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUT_SIZE - 1);
  localparam logic [ODX_W-1:0] ODX_LAST = ODX_W'(OUTPUT_SIZE - 1);

  // NFRAC only describes the number format; reject values that cannot fit.
  if (NFRAC < 0 || NFRAC >= WIDTH) begin : g_nfrac_check
    $error("NFRAC must lie in [0, WIDTH)");
  end

  ifc_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ODX_W-1:0]        odx_q, odx_d;
  logic signed [WIDTH-1:0] in_buf_q  [INPUT_SIZE];
  logic signed [WIDTH-1:0] in_buf_d  [INPUT_SIZE];
  logic signed [WIDTH-1:0] out_buf_q [OUTPUT_SIZE];
  logic signed [WIDTH-1:0] out_buf_d [OUTPUT_SIZE];
  logic                    err_len_q, err_len_d;
  logic                    err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]        frame_count_q, frame_count_d;
  logic [CNT_W-1:0]        last_latency_q, last_latency_d;
  logic [CNT_W-1:0]        max_latency_q, max_latency_d;

  logic                    s_ready, m_valid, m_last;
  logic signed [WIDTH-1:0] m_data;
  logic                    s_fire, m_fire;
  logic [CNT_W-1:0]        lat_count;
  logic                    lat_expired;

  assign s_fire = s_if.valid && s_ready;
  assign m_fire = m_valid && m_if.ready;

  lat_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_lat_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_START),
    .enable  (state_q == ST_WAIT),
    .count   (lat_count),
    .expired (lat_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_LOAD;
      idx_q          <= '0;
      odx_q          <= '0;
      in_buf_q       <= '{default: '0};
      out_buf_q      <= '{default: '0};
      err_len_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      frame_count_q  <= '0;
      last_latency_q <= '0;
      max_latency_q  <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      odx_q          <= odx_d;
      in_buf_q       <= in_buf_d;
      out_buf_q      <= out_buf_d;
      err_len_q      <= err_len_d;
      err_timeout_q  <= err_timeout_d;
      frame_count_q  <= frame_count_d;
      last_latency_q <= last_latency_d;
      max_latency_q  <= max_latency_d;
    end
  end

  // Core completion wins over timeout when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (s_fire && (idx_q == IDX_LAST)) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_output_ready) state_d = ST_DRAIN;
        else if (lat_expired)  state_d = ST_LOAD;
      end
      ST_DRAIN: if (m_fire && (odx_q == ODX_LAST)) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    s_ready          = reset && (state_q == ST_LOAD);
    m_valid          = (state_q == ST_DRAIN);
    m_last           = m_valid && (odx_q == ODX_LAST);
    m_data           = out_buf_q[odx_q];
    core_input_ready = (state_q == ST_START);
  end

  always_comb begin
    idx_d          = idx_q;
    odx_d          = odx_q;
    in_buf_d       = in_buf_q;
    out_buf_d      = out_buf_q;
    err_len_d      = err_len_q;
    err_timeout_d  = err_timeout_q;
    frame_count_d  = frame_count_q;
    last_latency_d = last_latency_q;
    max_latency_d  = max_latency_q;
    case (state_q)
      ST_LOAD: begin
        if (s_fire) begin
          if (idx_q == IDX_LAST) begin
            in_buf_d[idx_q] = s_if.data;
            idx_d           = '0;
            if (!s_if.last) err_len_d = 1'b1;
          end else if (s_if.last) begin
            err_len_d = 1'b1;
            idx_d     = '0;
          end else begin
            in_buf_d[idx_q] = s_if.data;
            idx_d           = idx_q + IDX_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (core_output_ready) begin
          out_buf_d      = core_output_data;
          last_latency_d = lat_count;
          if (lat_count > max_latency_q) max_latency_d = lat_count;
          if (frame_count_q != '1) frame_count_d = frame_count_q + CNT_W'(1);
        end else if (lat_expired) begin
          err_timeout_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (m_fire) odx_d = (odx_q == ODX_LAST) ? '0 : odx_q + ODX_W'(1);
      end
      default: ;
    endcase
  end

  assign s_if.ready      = s_ready;
  assign m_if.valid      = m_valid;
  assign m_if.last       = m_last;
  assign m_if.data       = m_data;
  assign core_input_data = in_buf_q;
  assign err_len         = err_len_q;
  assign err_timeout     = err_timeout_q;
  assign frame_count     = frame_count_q;
  assign last_latency    = last_latency_q;
  assign max_latency     = max_latency_q;

endmodule

// File: tb/tb_inference_frame_controller.sv
// Randomized self-checking bench: frames, core responses and output stalls are
// generated here and checked against a frame-level model of the controller.
module tb_inference_frame_controller;
  import ifc_pkg::*;

  localparam int W   = 37;
  localparam int IS  = 16;
  localparam int OS  = 5;
  localparam int TMO = 20;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  inference_frame_controller_if #(.WIDTH(W)) s_if ();
  inference_frame_controller_if #(.WIDTH(W)) m_if ();

  logic                core_input_ready;
  logic signed [W-1:0] core_input_data [IS];
  logic                core_output_ready;
  logic signed [W-1:0] core_output_data [OS];
  logic                err_len, err_timeout;
  logic [CW-1:0]       frame_count, last_latency, max_latency;

  inference_frame_controller #(
    .WIDTH(W), .NFRAC(24), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .s_if              (s_if),
    .m_if              (m_if),
    .core_input_ready  (core_input_ready),
    .core_input_data   (core_input_data),
    .core_output_ready (core_output_ready),
    .core_output_data  (core_output_data),
    .err_len           (err_len),
    .err_timeout       (err_timeout),
    .frame_count       (frame_count),
    .last_latency      (last_latency),
    .max_latency       (max_latency)
  );

  int total = 0;
  int bad   = 0;

  logic signed [W-1:0] tx [IS];
  logic signed [W-1:0] rx [OS];
  logic signed [W-1:0] obs_data [$];
  bit                  obs_last [$];
  int                  stall_bad;
  bit                  start_seen;

  // Frame-level reference model state.
  int exp_count, exp_last, exp_max;
  bit exp_err_len, exp_err_to;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_count = 0; exp_last = 0; exp_max = 0;
    exp_err_len = 1'b0; exp_err_to = 1'b0;
  endtask

  task automatic model_done(input int lat);
    if (exp_count < (1 << CW) - 1) exp_count++;
    exp_last = lat;
    if (lat > exp_max) exp_max = lat;
  endtask

  task automatic idle_inputs();
    s_if.valid = 1'b0; s_if.last = 1'b0; s_if.data = '0;
    m_if.ready = 1'b0; core_output_ready = 1'b0;
    foreach (core_output_data[i]) core_output_data[i] = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    model_clear();
  endtask

  task automatic fill_random();
    foreach (tx[i]) tx[i] = W'({$urandom(), $urandom()});
    foreach (rx[i]) rx[i] = W'({$urandom(), $urandom()});
  endtask

  task automatic send_beats(input int n, input bit with_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(2)) tick();
      s_if.valid = 1'b1;
      s_if.data  = tx[i];
      s_if.last  = with_last && (i == n - 1);
      begin
        int g = 0;
        while (!s_if.ready && g < 50) begin tick(); g++; end
        if (g == 50) begin
          total++; bad++;
          $display("[TB] FAIL s_ready_wait: got timeout want ready within 50 cycles");
        end
      end
      tick();
      s_if.valid = 1'b0;
      s_if.last  = 1'b0;
    end
  endtask

  task automatic wait_start();
    start_seen = 1'b0;
    for (int g = 0; g < 40; g++) begin
      if (core_input_ready) begin start_seen = 1'b1; break; end
      tick();
    end
  endtask

  task automatic do_done(input int lat);
    repeat (lat) tick();
    core_output_ready = 1'b1;
    foreach (rx[i]) core_output_data[i] = rx[i];
    tick();
    core_output_ready = 1'b0;
  endtask

  task automatic drain(input int mode);
    bit r, prev_stall;
    logic signed [W-1:0] prev_data;
    int k;
    obs_data.delete(); obs_last.delete();
    stall_bad = 0; prev_stall = 1'b0; prev_data = '0; k = 0;
    while (obs_data.size() < OS && k < 200) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (k % 3 == 0);
        default: r = 1'($urandom_range(1));
      endcase
      m_if.ready = r;
      if (prev_stall && m_if.valid && (m_if.data !== prev_data)) stall_bad++;
      if (m_if.valid && r) begin
        obs_data.push_back(m_if.data);
        obs_last.push_back(m_if.last);
      end
      prev_stall = m_if.valid && !r;
      prev_data  = m_if.data;
      tick();
      k++;
    end
    m_if.ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    tick();
    reset = 1'b0;
    #1;
    total++; if (s_if.ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_s_ready: got %0b want 0", s_if.ready); end
    total++; if (m_if.valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_m_valid: got %0b want 0", m_if.valid); end
    total++; if (core_input_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_core_start: got %0b want 0", core_input_ready); end
    total++; if ({err_len, err_timeout} !== 2'b00) begin bad++; $display("[TB] FAIL rst_errors: got %0b want 0", {err_len, err_timeout}); end
    total++; if ({frame_count, last_latency, max_latency} !== '0) begin bad++; $display("[TB] FAIL rst_stats: got %0d/%0d/%0d want 0", frame_count, last_latency, max_latency); end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    model_clear();
    total++; if (s_if.ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready: got %0b want 1", s_if.ready); end
  endtask

  task automatic test_basic();
    foreach (tx[i]) tx[i] = W'(i + 1);
    foreach (rx[i]) rx[i] = W'(100 + i);
    send_beats(IS, 1'b1, 1'b0);
    wait_start();
    total++; if (start_seen !== 1'b1) begin bad++; $display("[TB] FAIL basic_start: got %0b want 1", start_seen); end
    for (int i = 0; i < IS; i++) begin
      total++;
      if (core_input_data[i] !== W'(i + 1)) begin bad++; $display("[TB] FAIL basic_core_in[%0d]: got %0d want %0d", i, core_input_data[i], i + 1); end
    end
    do_done(7);
    model_done(7);
    drain(0);
    total++; if (obs_data.size() !== OS) begin bad++; $display("[TB] FAIL basic_out_count: got %0d want %0d", obs_data.size(), OS); end
    for (int i = 0; i < obs_data.size() && i < OS; i++) begin
      total++; if (obs_data[i] !== W'(100 + i)) begin bad++; $display("[TB] FAIL basic_m_data[%0d]: got %0d want %0d", i, obs_data[i], 100 + i); end
      total++; if (obs_last[i] !== (i == OS - 1)) begin bad++; $display("[TB] FAIL basic_m_last[%0d]: got %0b want %0b", i, obs_last[i], i == OS - 1); end
    end
    total++; if (last_latency !== CW'(7)) begin bad++; $display("[TB] FAIL basic_last_latency: got %0d want 7", last_latency); end
    total++; if (frame_count !== CW'(exp_count)) begin bad++; $display("[TB] FAIL basic_frame_count: got %0d want %0d", frame_count, exp_count); end
    total++; if (err_len !== exp_err_len) begin bad++; $display("[TB] FAIL basic_err_len: got %0b want %0b", err_len, exp_err_len); end
    total++; if (m_if.valid !== 1'b0 || s_if.ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_back_to_load: got valid=%0b ready=%0b want 0/1", m_if.valid, s_if.ready); end
  endtask

  task automatic test_missing_last();
    fill_random();
    send_beats(IS, 1'b0, 1'b0);
    exp_err_len = 1'b1;
    wait_start();
    total++; if (start_seen !== 1'b1) begin bad++; $display("[TB] FAIL nolast_start: got %0b want 1", start_seen); end
    total++; if (err_len !== exp_err_len) begin bad++; $display("[TB] FAIL nolast_err_len: got %0b want %0b", err_len, exp_err_len); end
    do_done(4);
    model_done(4);
    drain(0);
    total++; if (obs_data.size() !== OS) begin bad++; $display("[TB] FAIL nolast_out_count: got %0d want %0d", obs_data.size(), OS); end
    for (int i = 0; i < obs_data.size() && i < OS; i++) begin
      total++; if (obs_data[i] !== rx[i]) begin bad++; $display("[TB] FAIL nolast_m_data[%0d]: got %0d want %0d", i, obs_data[i], rx[i]); end
    end
    total++; if (frame_count !== CW'(exp_count)) begin bad++; $display("[TB] FAIL nolast_frame_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_reset_mid_wait();
    int nz, seen_valid;
    fill_random();
    send_beats(IS, 1'b1, 1'b0);
    wait_start();
    repeat (3) tick();
    reset = 1'b0;
    #1;
    nz = 0;
    foreach (core_input_data[i]) if (core_input_data[i] !== '0) nz++;
    total++; if (nz !== 0) begin bad++; $display("[TB] FAIL midrst_core_in_zero: got %0d nonzero want 0", nz); end
    total++; if (m_if.valid !== 1'b0 || m_if.data !== '0) begin bad++; $display("[TB] FAIL midrst_m_out: got valid=%0b data=%0d want 0", m_if.valid, m_if.data); end
    total++; if (s_if.ready !== 1'b0 || core_input_ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ready: got %0b/%0b want 0", s_if.ready, core_input_ready); end
    total++; if ({err_len, err_timeout} !== 2'b00) begin bad++; $display("[TB] FAIL midrst_errors: got %0b want 0", {err_len, err_timeout}); end
    total++; if ({frame_count, last_latency, max_latency} !== '0) begin bad++; $display("[TB] FAIL midrst_stats: got %0d/%0d/%0d want 0", frame_count, last_latency, max_latency); end
    tick();
    reset = 1'b1;
    model_clear();
    tick();
    core_output_ready = 1'b1;
    foreach (rx[i]) core_output_data[i] = rx[i];
    seen_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      core_output_ready = 1'b0;
      if (m_if.valid) seen_valid++;
    end
    total++; if (seen_valid !== 0) begin bad++; $display("[TB] FAIL midrst_stray_done: got %0d valid cycles want 0", seen_valid); end
    total++; if (frame_count !== CW'(0)) begin bad++; $display("[TB] FAIL midrst_count_after: got %0d want 0", frame_count); end
    fill_random();
    send_beats(IS, 1'b1, 1'b0);
    wait_start();
    nz = 0;
    foreach (core_input_data[i]) if (core_input_data[i] !== tx[i]) nz++;
    total++; if (nz !== 0) begin bad++; $display("[TB] FAIL midrst_next_frame_in: got %0d wrong features want 0", nz); end
    do_done(2);
    model_done(2);
    drain(0);
    total++; if (obs_data.size() !== OS) begin bad++; $display("[TB] FAIL midrst_next_out_count: got %0d want %0d", obs_data.size(), OS); end
    for (int i = 0; i < obs_data.size() && i < OS; i++) begin
      total++; if (obs_data[i] !== rx[i]) begin bad++; $display("[TB] FAIL midrst_next_m_data[%0d]: got %0d want %0d", i, obs_data[i], rx[i]); end
    end
    total++; if (frame_count !== CW'(exp_count) || last_latency !== CW'(exp_last)) begin bad++; $display("[TB] FAIL midrst_next_stats: got %0d/%0d want %0d/%0d", frame_count, last_latency, exp_count, exp_last); end
  endtask

  task automatic test_short_frame();
    int starts, nz;
    fill_random();
    send_beats(5, 1'b1, 1'b0);
    exp_err_len = 1'b1;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      if (core_input_ready) starts++;
      tick();
    end
    total++; if (starts !== 0) begin bad++; $display("[TB] FAIL short_no_start: got %0d starts want 0", starts); end
    total++; if (err_len !== exp_err_len) begin bad++; $display("[TB] FAIL short_err_len: got %0b want %0b", err_len, exp_err_len); end
    total++; if (s_if.ready !== 1'b1) begin bad++; $display("[TB] FAIL short_stays_load: got %0b want 1", s_if.ready); end
    fill_random();
    send_beats(IS, 1'b1, 1'b0);
    wait_start();
    total++; if (start_seen !== 1'b1) begin bad++; $display("[TB] FAIL short_next_start: got %0b want 1", start_seen); end
    nz = 0;
    foreach (core_input_data[i]) if (core_input_data[i] !== tx[i]) nz++;
    total++; if (nz !== 0) begin bad++; $display("[TB] FAIL short_next_frame_in: got %0d wrong features want 0", nz); end
    do_done(3);
    model_done(3);
    drain(0);
    total++; if (obs_data.size() !== OS) begin bad++; $display("[TB] FAIL short_next_out_count: got %0d want %0d", obs_data.size(), OS); end
    for (int i = 0; i < obs_data.size() && i < OS; i++) begin
      total++; if (obs_data[i] !== rx[i]) begin bad++; $display("[TB] FAIL short_next_m_data[%0d]: got %0d want %0d", i, obs_data[i], rx[i]); end
    end
    total++; if (frame_count !== CW'(exp_count)) begin bad++; $display("[TB] FAIL short_next_frame_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_timeout();
    fill_random();
    send_beats(IS, 1'b1, 1'b0);
    wait_start();
    repeat (TMO) tick();
    total++; if (err_timeout !== 1'b0) begin bad++; $display("[TB] FAIL timeout_early: got %0b want 0", err_timeout); end
    tick();
    exp_err_to = 1'b1;
    total++; if (err_timeout !== exp_err_to) begin bad++; $display("[TB] FAIL timeout_flag: got %0b want %0b", err_timeout, exp_err_to); end
    total++; if (s_if.ready !== 1'b1) begin bad++; $display("[TB] FAIL timeout_back_to_load: got %0b want 1", s_if.ready); end
    total++; if (frame_count !== CW'(exp_count) || last_latency !== CW'(exp_last)) begin bad++; $display("[TB] FAIL timeout_stats: got %0d/%0d want %0d/%0d", frame_count, last_latency, exp_count, exp_last); end
    core_output_ready = 1'b1;
    tick();
    core_output_ready = 1'b0;
    tick();
    total++; if (m_if.valid !== 1'b0 || frame_count !== CW'(exp_count)) begin bad++; $display("[TB] FAIL timeout_late_done: got valid=%0b count=%0d want 0/%0d", m_if.valid, frame_count, exp_count); end
  endtask

  task automatic test_backpressure();
    fill_random();
    send_beats(IS, 1'b1, 1'b0);
    wait_start();
    do_done(5);
    model_done(5);
    drain(1);
    total++; if (obs_data.size() !== OS) begin bad++; $display("[TB] FAIL bp_out_count: got %0d want %0d", obs_data.size(), OS); end
    for (int i = 0; i < obs_data.size() && i < OS; i++) begin
      total++; if (obs_data[i] !== rx[i]) begin bad++; $display("[TB] FAIL bp_m_data[%0d]: got %0d want %0d", i, obs_data[i], rx[i]); end
      total++; if (obs_last[i] !== (i == OS - 1)) begin bad++; $display("[TB] FAIL bp_m_last[%0d]: got %0b want %0b", i, obs_last[i], i == OS - 1); end
    end
    total++; if (stall_bad !== 0) begin bad++; $display("[TB] FAIL bp_stall_stable: got %0d changes want 0", stall_bad); end
    total++; if (m_if.valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_extra_beat: got %0b want 0", m_if.valid); end
  endtask

  task automatic test_latency_stats();
    int lats [3] = '{3, 9, 5};
    do_reset();
    foreach (lats[f]) begin
      fill_random();
      send_beats(IS, 1'b1, 1'b0);
      wait_start();
      do_done(lats[f]);
      model_done(lats[f]);
      drain(0);
    end
    total++; if (max_latency !== CW'(exp_max)) begin bad++; $display("[TB] FAIL stats_max: got %0d want %0d", max_latency, exp_max); end
    total++; if (last_latency !== CW'(exp_last)) begin bad++; $display("[TB] FAIL stats_last: got %0d want %0d", last_latency, exp_last); end
    total++; if (frame_count !== CW'(exp_count)) begin bad++; $display("[TB] FAIL stats_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int lat;
      lat = $urandom_range(TMO - 1, 1);
      fill_random();
      send_beats(IS, 1'b1, 1'b1);
      wait_start();
      do_done(lat);
      model_done(lat);
      drain(2);
      total++; if (obs_data.size() !== OS) begin bad++; $display("[TB] FAIL rnd_out_count: got %0d want %0d", obs_data.size(), OS); end
      for (int i = 0; i < obs_data.size() && i < OS; i++) begin
        total++; if (obs_data[i] !== rx[i]) begin bad++; $display("[TB] FAIL rnd_m_data[%0d]: got %0d want %0d", i, obs_data[i], rx[i]); end
      end
      total++; if (stall_bad !== 0) begin bad++; $display("[TB] FAIL rnd_stall_stable: got %0d changes want 0", stall_bad); end
      total++; if (last_latency !== CW'(exp_last) || max_latency !== CW'(exp_max) || frame_count !== CW'(exp_count)) begin
        bad++;
        $display("[TB] FAIL rnd_stats: got %0d/%0d/%0d want %0d/%0d/%0d", last_latency, max_latency, frame_count, exp_last, exp_max, exp_count);
      end
    end
    total++; if ({err_len, err_timeout} !== {exp_err_len, exp_err_to}) begin bad++; $display("[TB] FAIL rnd_errors: got %0b want %0b", {err_len, err_timeout}, {exp_err_len, exp_err_to}); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_missing_last();
    test_reset_mid_wait();
    test_short_frame();
    test_timeout();
    test_backpressure();
    test_latency_stats();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
